// File: rtl/conv_pkg.sv
// Shared defaults and state encoding for the convolution controller.
package conv_pkg;

   localparam int DEF_DATA_W  = 16;
   localparam int DEF_MAP_DIM = 6;
   localparam int DEF_K_DIM   = 3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_K,
      S_LOAD_MAP,
      S_MAC,
      S_EMIT,
      S_DONE
   } state_t;

endpackage

// File: rtl/conv_mac.sv
// Registered multiply-accumulate with clear, enable and zero-tap mask.
module conv_mac #(
   parameter int DATA_W = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clr_i,
   input  logic              en_i,
   input  logic              zero_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic [DATA_W-1:0] acc_o
);

   logic [DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0] prod;

   // Only the low DATA_W bits of the product are kept; the sum wraps.
   assign prod = a_i * b_i;

   always_comb begin
      acc_d = acc_q;
      if (clr_i)
         acc_d = '0;
      else if (en_i)
         acc_d = acc_q + (zero_i ? '0 : prod);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         acc_q <= '0;
      else
         acc_q <= acc_d;
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/conv_ctrl.sv
// Streaming 2-D convolution controller: loads kernel/map words, then computes
// one output per K_DIM*K_DIM MAC cycles and emits them in row-major order.
module conv_ctrl
   import conv_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int MAP_DIM = DEF_MAP_DIM,
   parameter int K_DIM   = DEF_K_DIM
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              reload_k,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              busy,
   output logic              done
);

   localparam int MAP_N = MAP_DIM * MAP_DIM;
   localparam int K_N   = K_DIM * K_DIM;
   localparam int CW    = (MAP_N > 1) ? $clog2(MAP_N) : 1;
   localparam int KW    = (K_N > 1) ? $clog2(K_N) : 1;
   localparam int RW    = $clog2(MAP_DIM + 1);
   localparam int TW    = $clog2(K_DIM + 1);

   state_t            state_q, state_d;
   logic [CW-1:0]     ld_q, ld_d;
   logic [RW-1:0]     oi_q, oi_d, oj_q, oj_d;
   logic [TW-1:0]     tm_q, tm_d, tn_q, tn_d;

   logic [DATA_W-1:0] kern_q [K_N];
   logic [DATA_W-1:0] map_q  [MAP_N];

   logic              kern_we, map_we, mac_clr, mac_en, tap_zero;
   logic [CW-1:0]     tap_addr;
   logic [KW-1:0]     kern_addr;
   logic [DATA_W-1:0] acc;

   // Taps falling off the bottom/right edge are masked but still take a cycle.
   always_comb begin
      int r, c;
      r         = int'(oi_q) + int'(tm_q);
      c         = int'(oj_q) + int'(tn_q);
      tap_zero  = (r >= MAP_DIM) || (c >= MAP_DIM);
      tap_addr  = tap_zero ? '0 : CW'(r * MAP_DIM + c);
      kern_addr = KW'(int'(tm_q) * K_DIM + int'(tn_q));
   end

   always_comb begin
      state_d   = state_q;
      ld_d      = ld_q;
      oi_d      = oi_q;
      oj_d      = oj_q;
      tm_d      = tm_q;
      tn_d      = tn_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      done      = 1'b0;
      kern_we   = 1'b0;
      map_we    = 1'b0;
      mac_clr   = 1'b0;
      mac_en    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               ld_d    = '0;
               state_d = reload_k ? S_LOAD_K : S_LOAD_MAP;
            end
         end
         S_LOAD_K: begin
            in_ready = 1'b1;
            if (in_valid) begin
               kern_we = 1'b1;
               if (ld_q == CW'(K_N - 1)) begin
                  ld_d    = '0;
                  state_d = S_LOAD_MAP;
               end else begin
                  ld_d = ld_q + CW'(1);
               end
            end
         end
         S_LOAD_MAP: begin
            in_ready = 1'b1;
            if (in_valid) begin
               map_we = 1'b1;
               if (ld_q == CW'(MAP_N - 1)) begin
                  ld_d    = '0;
                  oi_d    = '0;
                  oj_d    = '0;
                  tm_d    = '0;
                  tn_d    = '0;
                  mac_clr = 1'b1;
                  state_d = S_MAC;
               end else begin
                  ld_d = ld_q + CW'(1);
               end
            end
         end
         S_MAC: begin
            mac_en = 1'b1;
            if (tn_q == TW'(K_DIM - 1)) begin
               tn_d = '0;
               if (tm_q == TW'(K_DIM - 1)) begin
                  tm_d    = '0;
                  state_d = S_EMIT;
               end else begin
                  tm_d = tm_q + TW'(1);
               end
            end else begin
               tn_d = tn_q + TW'(1);
            end
         end
         S_EMIT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               if (oi_q == RW'(MAP_DIM - 1) && oj_q == RW'(MAP_DIM - 1)) begin
                  state_d = S_DONE;
               end else begin
                  mac_clr = 1'b1;
                  state_d = S_MAC;
                  if (oj_q == RW'(MAP_DIM - 1)) begin
                     oj_d = '0;
                     oi_d = oi_q + RW'(1);
                  end else begin
                     oj_d = oj_q + RW'(1);
                  end
               end
            end
         end
         S_DONE: begin
            done    = 1'b1;
            oi_d    = '0;
            oj_d    = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         ld_q    <= '0;
         oi_q    <= '0;
         oj_q    <= '0;
         tm_q    <= '0;
         tn_q    <= '0;
      end else begin
         state_q <= state_d;
         ld_q    <= ld_d;
         oi_q    <= oi_d;
         oj_q    <= oj_d;
         tm_q    <= tm_d;
         tn_q    <= tn_d;
      end
   end

   // Kernel survives between runs; reset restores the all-ones kernel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < K_N; k++)
            kern_q[k] <= DATA_W'(1);
      end else if (kern_we) begin
         kern_q[KW'(ld_q)] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (map_we)
         map_q[ld_q] <= in_data;
   end

   conv_mac #(.DATA_W(DATA_W)) u_mac (
      .clk_i  (clk),
      .rst_i  (rst),
      .clr_i  (mac_clr),
      .en_i   (mac_en),
      .zero_i (tap_zero),
      .a_i    (map_q[tap_addr]),
      .b_i    (kern_q[kern_addr]),
      .acc_o  (acc)
   );

   assign busy     = (state_q != S_IDLE);
   assign out_data = acc;

endmodule

// File: tb/tb_conv_ctrl.sv
// Scoreboard bench for conv_ctrl: expected outputs are queued per run from a
// direct convolution model and popped as the DUT emits results.
module tb_conv_ctrl;

   localparam int DW = 16;
   localparam int MD = 6;
   localparam int KD = 3;
   localparam int MN = MD * MD;
   localparam int KN = KD * KD;

   logic          clk = 1'b0;
   logic          rst, start, reload_k, in_valid, out_ready;
   logic          in_ready, out_valid, busy, done;
   logic [DW-1:0] in_data, out_data;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int done_cnt = 0;

   logic [DW-1:0] kern_v   [KN];
   logic [DW-1:0] map_v    [MN];
   logic [DW-1:0] mdl_kern [KN];
   logic [DW-1:0] got      [MN];
   logic [DW-1:0] exp_q    [$];

   conv_ctrl #(.DATA_W(DW), .MAP_DIM(MD), .K_DIM(KD)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .reload_k  (reload_k),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (done) done_cnt <= done_cnt + 1;
   end

   task automatic push_expected();
      for (int i = 0; i < MD; i++)
         for (int j = 0; j < MD; j++) begin
            logic [DW-1:0] s;
            s = '0;
            for (int m = 0; m < KD; m++)
               for (int n = 0; n < KD; n++)
                  if (i + m < MD && j + n < MD)
                     s += mdl_kern[m*KD+n] * map_v[(i+m)*MD + j + n];
            exp_q.push_back(s);
         end
   endtask

   task automatic run(input bit reload, input int stall_k, input int abort_k,
                      input bit pulse, input string tag);
      int t0, wn, d0, lat, nin;
      logic [DW-1:0] e, hold;
      if (reload) mdl_kern = kern_v;
      exp_q.delete();
      push_expected();
      d0 = done_cnt;
      start = 1'b1; reload_k = reload;
      @(posedge clk); #1;
      start = 1'b0; reload_k = 1'b0;
      t0 = cyc;
      nin = (reload ? KN : 0) + MN;
      for (int n = 0; n < nin; n++) begin
         in_valid = 1'b1;
         in_data  = (reload && n < KN) ? kern_v[n] : map_v[n - (reload ? KN : 0)];
         if (pulse && n == nin - 20) begin start = 1'b1; reload_k = 1'b1; end
         wn = 0;
         while (!in_ready && wn < 50) begin @(posedge clk); #1; wn++; end
         if (wn >= 50) begin
            checks++; failures++;
            $display("FAIL %s in_ready timeout word %0d", tag, n);
         end
         @(posedge clk); #1;
         start = 1'b0; reload_k = 1'b0;
      end
      in_valid = 1'b0;
      for (int k = 0; k < MN; k++) begin
         if (k == abort_k) begin
            repeat (3) @(posedge clk);
            #1 rst = 1'b1;
            #1;
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
               failures++;
               $display("FAIL %s abort_async: out_valid=%b busy=%b in_ready=%b required 0/0/0",
                        tag, out_valid, busy, in_ready);
            end
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0) begin
               failures++;
               $display("FAIL %s abort_edge: out_valid=%b busy=%b out_data=%h required 0/0/0",
                        tag, out_valid, busy, out_data);
            end
            rst = 1'b0;
            repeat (5) @(posedge clk); #1;
            checks++;
            if (done_cnt != d0 || busy !== 1'b0 || out_valid !== 1'b0) begin
               failures++;
               $display("FAIL %s abort_quiet: done_pulses=%0d busy=%b out_valid=%b required 0/0/0",
                        tag, done_cnt - d0, busy, out_valid);
            end
            for (int q = 0; q < KN; q++) mdl_kern[q] = DW'(1);
            exp_q.delete();
            return;
         end
         wn = 0;
         while (!out_valid && wn < 50) begin @(posedge clk); #1; wn++; end
         if (wn >= 50) begin
            checks++; failures++;
            $display("FAIL %s out_valid timeout out[%0d]", tag, k);
         end
         if (k == stall_k) begin
            out_ready = 1'b0;
            hold = out_data;
            repeat (5) begin
               @(posedge clk); #1;
               checks++;
               if (out_data !== hold || out_valid !== 1'b1 || busy !== 1'b1) begin
                  failures++;
                  $display("FAIL %s stall: out_data=%h out_valid=%b busy=%b required %h/1/1",
                           tag, out_data, out_valid, busy, hold);
               end
            end
            out_ready = 1'b1;
         end
         if (pulse && k == 3) begin start = 1'b1; reload_k = 1'b1; end
         e = exp_q.pop_front();
         got[k] = out_data;
         checks++;
         if (out_data !== e) begin
            failures++;
            $display("FAIL %s out[%0d]: got %h required %h", tag, k, out_data, e);
         end
         @(posedge clk); #1;
         start = 1'b0; reload_k = 1'b0;
      end
      checks++;
      if (done !== 1'b1 || busy !== 1'b1) begin
         failures++;
         $display("FAIL %s done_pulse: done=%b busy=%b required 1/1", tag, done, busy);
      end
      if (stall_k < 0) begin
         lat = (reload ? KN : 0) + MN + MN * (KN + 1);
         checks++;
         if (cyc - t0 != lat) begin
            failures++;
            $display("FAIL %s latency: got %0d required %0d", tag, cyc - t0, lat);
         end
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || done_cnt != d0 + 1) begin
         failures++;
         $display("FAIL %s done_end: done=%b busy=%b pulses=%0d required 0/0/1",
                  tag, done, busy, done_cnt - d0);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; reload_k = 1'b0; in_valid = 1'b0;
      in_data = '0; out_ready = 1'b1;
      repeat (2) @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 ||
          done !== 1'b0 || out_data !== '0) begin
         failures++;
         $display("FAIL reset: in_ready=%b out_valid=%b busy=%b done=%b out_data=%h required all 0",
                  in_ready, out_valid, busy, done, out_data);
      end
      rst = 1'b0;
      for (int q = 0; q < KN; q++) mdl_kern[q] = DW'(1);
      @(posedge clk); #1;
   endtask

   task automatic test_ones_map();
      for (int q = 0; q < MN; q++) map_v[q] = DW'(1);
      run(1'b0, -1, -1, 1'b0, "ones");
      checks++;
      if (got[0] !== 16'd9 || got[4] !== 16'd6 || got[5] !== 16'd3 ||
          got[30] !== 16'd3 || got[35] !== 16'd1) begin
         failures++;
         $display("FAIL ones_spot: got %0d %0d %0d %0d %0d required 9 6 3 3 1",
                  got[0], got[4], got[5], got[30], got[35]);
      end
   endtask

   task automatic test_identity_kernel();
      int bad;
      for (int q = 0; q < KN; q++) kern_v[q] = (q == 0) ? DW'(1) : '0;
      for (int q = 0; q < MN; q++) map_v[q] = DW'(q);
      run(1'b1, -1, -1, 1'b0, "ident");
      bad = 0;
      for (int q = 0; q < MN; q++) if (got[q] !== DW'(q)) bad++;
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL ident_all: %0d outputs differ from index, required 0", bad);
      end
   endtask

   task automatic test_wrap();
      for (int q = 0; q < KN; q++) kern_v[q] = DW'(1);
      for (int q = 0; q < MN; q++) map_v[q] = 16'h4000;
      run(1'b1, -1, -1, 1'b0, "wrap");
      checks++;
      if (got[0] !== 16'h4000 || got[4] !== 16'h8000 || got[35] !== 16'h4000) begin
         failures++;
         $display("FAIL wrap_spot: got %h %h %h required 4000 8000 4000",
                  got[0], got[4], got[35]);
      end
   endtask

   task automatic test_backpressure();
      for (int q = 0; q < KN; q++) kern_v[q] = DW'($urandom_range(0, 65535));
      for (int q = 0; q < MN; q++) map_v[q] = DW'($urandom_range(0, 65535));
      run(1'b1, 7, -1, 1'b0, "stall");
   endtask

   task automatic test_start_ignored();
      for (int q = 0; q < MN; q++) map_v[q] = DW'($urandom_range(0, 300));
      run(1'b0, -1, -1, 1'b1, "start_ign");
   endtask

   task automatic test_abort_and_recover();
      for (int q = 0; q < KN; q++) kern_v[q] = DW'($urandom_range(2, 50));
      for (int q = 0; q < MN; q++) map_v[q] = DW'($urandom_range(0, 1000));
      run(1'b1, -1, 10, 1'b0, "abort");
      for (int q = 0; q < MN; q++) map_v[q] = DW'($urandom_range(0, 1000));
      run(1'b0, -1, -1, 1'b0, "after_abort");
   endtask

   initial begin
      test_reset();
      test_ones_map();
      test_identity_kernel();
      test_wrap();
      test_backpressure();
      test_start_ignored();
      test_abort_and_recover();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/conv_ctrl.md
CONV_CTRL -- requirements
Module: conv_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning word width of map, kernel and result.
REQ-002 SHALL have parameter MAP_DIM, default 6, meaning feature-map side length (map is MAP_DIM x MAP_DIM, row-major).
REQ-003 SHALL have parameter K_DIM, default 3, meaning kernel side length.
REQ-004 SHALL run on one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 start  input  1  one-cycle request to begin a run; sampled only in IDLE.
REQ-008 reload_k  input  1  sampled with start; 1 = load new kernel before map.
REQ-009 in_valid  input  1  input word valid.
REQ-010 in_ready  output  1  controller accepts input word.
REQ-011 in_data  input  DATA_W  kernel word (LOAD_K) or map word (LOAD_MAP), row-major.
REQ-012 out_valid  output  1  result word valid.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 out_data  output  DATA_W  result word, row-major order.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse after last result handshake.

Function
REQ-017 States: IDLE, LOAD_K, LOAD_MAP, MAC, EMIT, DONE.
- IDLE: start&reload_k -> LOAD_K; start&!reload_k -> LOAD_MAP.
- LOAD_K: K_DIM*K_DIM handshakes -> LOAD_MAP.
- LOAD_MAP: MAP_DIM*MAP_DIM handshakes -> MAC.
- MAC: exactly K_DIM*K_DIM cycles per output -> EMIT.
- EMIT: out_valid=1; on out_ready, last output -> DONE, else -> MAC with next index.
- DONE: done=1 for one cycle -> IDLE.
REQ-018 Handshake transfers when valid&ready on a rising edge; in_ready=1 only in LOAD_K/LOAD_MAP; in_valid ignored elsewhere.
REQ-019 out_data SHALL hold stable while out_valid=1 and out_ready=0; no state advance.
REQ-020 Output(i,j) = sum over m,n in [0,K_DIM) of map[i+m][j+n]*kernel[m][n]; taps with i+m>=MAP_DIM or j+n>=MAP_DIM contribute 0 but still consume a MAC cycle.
REQ-021 Product truncated to low DATA_W bits; accumulator DATA_W bits, wraps modulo 2^DATA_W.
REQ-022 Accumulator cleared on entry to MAC for each output.
REQ-023 Kernel store SHALL persist across runs; map store overwritten every run.
REQ-024 start outside IDLE SHALL be ignored.
REQ-025 Run latency with in_valid and out_ready held high: (reload_k?9:0)+36 load cycles, then 36*(9+1) cycles, then 1 DONE cycle.

Reset
REQ-026 On rst: state IDLE; in_ready, out_valid, busy, done = 0; out_data = 0; all counters 0; kernel store = all 1; accumulator 0.
REQ-027 Reset mid-run SHALL abandon the run, discard partial map, emit no further outputs and no done.

Structure
REQ-028 Shared package conv_pkg SHALL hold DATA_W, MAP_DIM, K_DIM defaults and the state enum typedef.
REQ-029 Single sub-module conv_mac: registered multiply-accumulate with clear, enable and zero-tap mask.

Verification
REQ-030 Reset, start reload_k=0, map all 1 -> out[0]=9, out[4]=6, out[5]=3, out[30]=3, out[35]=1; done after 36th handshake.
REQ-031 reload_k=1, kernel {1,0,0,0,0,0,0,0,0}, map 0..35 -> out[k]=k for all k.
REQ-032 Kernel all 1, map all 0x4000 -> out[0]=0x4000 (0x24000 wrapped), out[35]=0x4000.
REQ-033 out_ready low 5 cycles while out_valid for out[7] -> out_data constant, busy=1, subsequent outputs correct.
REQ-034 rst asserted during MAC of out[10] -> out_valid=0, busy=0 next edge, no done; next run reload_k=0 uses all-1 kernel.
REQ-035 start pulsed during LOAD_MAP and EMIT -> ignored; result stream and done count unchanged.
